flag_alu_pipe: RTL and testbench

Parametrised, registered successor to the single-cycle datapath ALU. It accepts one operation per cycle over a valid/ready handshake and evaluates the ARM condition field against an internal NZCV register. It computes all 16 data-processing ops, including ADC/SBC/RSC, plus an iterative multi-cycle MUL. Registered results and flags go to the register-file writeback stage.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/cond_check.sv | 39 +++
 rtl/flag_alu_pipe.sv | 164 ++++++++++++++++
 tb/tb_flag_alu_pipe.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the flag-setting ALU pipeline: opcodes, ARM condition
// codes, NZCV bit positions and the multiply sequencer states.
package alu_pkg;

    localparam logic [4:0] OP_AND = 5'h00;
    localparam logic [4:0] OP_EOR = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_RSB = 5'h03;
    localparam logic [4:0] OP_ADD = 5'h04;
    localparam logic [4:0] OP_ADC = 5'h05;
    localparam logic [4:0] OP_SBC = 5'h06;
    localparam logic [4:0] OP_RSC = 5'h07;
    localparam logic [4:0] OP_TST = 5'h08;
    localparam logic [4:0] OP_TEQ = 5'h09;
    localparam logic [4:0] OP_CMP = 5'h0A;
    localparam logic [4:0] OP_CMN = 5'h0B;
    localparam logic [4:0] OP_ORR = 5'h0C;
    localparam logic [4:0] OP_MOV = 5'h0D;
    localparam logic [4:0] OP_BIC = 5'h0E;
    localparam logic [4:0] OP_MVN = 5'h0F;
    localparam logic [4:0] OP_MUL = 5'h10;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluator against an NZCV vector; the NV encoding never passes.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_alu_pipe.sv
// Registered ALU with condition evaluation, NZCV register and an iterative
// shift-add multiplier. One op per cycle except MUL, which stalls the input.
module flag_alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [4:0]       opcode,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             execute,
    output logic             wr_en,
    output logic [3:0]       flags
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [3:0]       nzcv;
    logic             pass;
    logic             accept;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [CNT_W-1:0] cnt;
    logic             mul_set;

    logic [WIDTH-1:0] op_a, op_b, lres, alu_res;
    logic             cin, arith;
    logic [WIDTH:0]   sum;
    logic [3:0]       new_nzcv;
    logic             mul_op, op_def, no_wb;

    cond_check u_cond (
        .cond  (cond),
        .flags (nzcv),
        .pass  (pass)
    );

    assign in_ready = reset && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign flags    = nzcv;

    assign mul_op = MUL_EN && (opcode == OP_MUL);
    assign op_def = (opcode <= OP_MVN) || mul_op;
    assign no_wb  = (opcode >= OP_TST) && (opcode <= OP_CMN);

    // Subtracts feed the inverted operand into the adder so C means "no borrow"
    // and V is judged on the adder's actual inputs.
    always_comb begin
        op_a  = data1;
        op_b  = data2;
        cin   = 1'b0;
        arith = 1'b0;
        lres  = '0;
        case (opcode)
            OP_AND, OP_TST: lres = data1 & data2;
            OP_EOR, OP_TEQ: lres = data1 ^ data2;
            OP_SUB, OP_CMP: begin arith = 1'b1; op_b = ~data2; cin = 1'b1; end
            OP_RSB: begin arith = 1'b1; op_a = data2; op_b = ~data1; cin = 1'b1; end
            OP_ADD, OP_CMN: arith = 1'b1;
            OP_ADC: begin arith = 1'b1; cin = nzcv[FLAG_C]; end
            OP_SBC: begin arith = 1'b1; op_b = ~data2; cin = nzcv[FLAG_C]; end
            OP_RSC: begin arith = 1'b1; op_a = data2; op_b = ~data1; cin = nzcv[FLAG_C]; end
            OP_ORR: lres = data1 | data2;
            OP_MOV: lres = data2;
            OP_BIC: lres = data1 & ~data2;
            OP_MVN: lres = ~data2;
            default: lres = '0;
        endcase
    end

    assign sum     = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    assign alu_res = arith ? sum[WIDTH-1:0] : lres;

    always_comb begin
        new_nzcv         = nzcv;
        new_nzcv[FLAG_N] = alu_res[WIDTH-1];
        new_nzcv[FLAG_Z] = (alu_res == '0);
        if (arith) begin
            new_nzcv[FLAG_C] = sum[WIDTH];
            new_nzcv[FLAG_V] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                               (sum[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            nzcv      <= 4'b0000;
            result    <= '0;
            out_valid <= 1'b0;
            execute   <= 1'b0;
            wr_en     <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            mul_set   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!op_def) begin
                            out_valid <= 1'b1;
                            execute   <= 1'b0;
                            wr_en     <= 1'b0;
                            result    <= '0;
                        end else if (!pass) begin
                            out_valid <= 1'b1;
                            execute   <= 1'b0;
                            wr_en     <= 1'b0;
                        end else if (mul_op) begin
                            state   <= MUL_BUSY;
                            mcand   <= data1;
                            mplier  <= data2;
                            acc     <= '0;
                            cnt     <= '0;
                            mul_set <= set_flags;
                        end else begin
                            out_valid <= 1'b1;
                            execute   <= 1'b1;
                            wr_en     <= !no_wb;
                            result    <= alu_res;
                            if (set_flags)
                                nzcv <= new_nzcv;
                        end
                    end
                end
                MUL_BUSY: begin
                    // Only the low WIDTH bits are kept, which is also correct for signed operands.
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= MUL_DONE;
                end
                MUL_DONE: begin
                    out_valid <= 1'b1;
                    execute   <= 1'b1;
                    wr_en     <= 1'b1;
                    result    <= acc;
                    if (mul_set) begin
                        nzcv[FLAG_N] <= acc[WIDTH-1];
                        nzcv[FLAG_Z] <= (acc == '0);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_alu_pipe.sv
// Directed-vector bench for flag_alu_pipe with hand-computed expectations.
module tb_flag_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   cond = 4'h0;
    logic [4:0]   opcode = 5'h0;
    logic         set_flags = 1'b0;
    logic [W-1:0] data1 = '0, data2 = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         execute, wr_en;
    logic [3:0]   flags;

    int n_chk = 0;
    int n_err = 0;

    flag_alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cond      (cond),
        .opcode    (opcode),
        .set_flags (set_flags),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .result    (result),
        .execute   (execute),
        .wr_en     (wr_en),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op for a single edge, then sample #1 after that edge.
    task automatic op(input logic [3:0] c, input logic [4:0] o, input logic s,
                      input logic [W-1:0] a, input logic [W-1:0] b);
        cond = c; opcode = o; set_flags = s; data1 = a; data2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int seen;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", W'(flags), W'(4'b0000));
        chk("rst_ovalid", W'(out_valid), W'(1'b0));
        chk("rst_ready", W'(in_ready), W'(1'b0));
        chk("rst_result", result, '0);
        @(negedge clk); reset = 1'b1; #1;
        chk("rel_ready", W'(in_ready), W'(1'b1));

        // ADD overflow into sign bit
        op(CC_AL, OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1);
        chk("add_ovalid", W'(out_valid), W'(1'b1));
        chk("add_result", result, 32'h8000_0000);
        chk("add_exec", W'(execute), W'(1'b1));
        chk("add_wr", W'(wr_en), W'(1'b1));
        chk("add_flags", W'(flags), W'(4'b1001));

        // CMP then dependent SUB EQ back-to-back
        op(CC_AL, OP_CMP, 1'b1, 32'd5, 32'd5);
        chk("cmp_wr", W'(wr_en), W'(1'b0));
        chk("cmp_exec", W'(execute), W'(1'b1));
        chk("cmp_flags", W'(flags), W'(4'b0110));
        op(CC_EQ, OP_SUB, 1'b0, 32'd9, 32'd4);
        chk("subeq_exec", W'(execute), W'(1'b1));
        chk("subeq_result", result, 32'd5);
        chk("subeq_flags", W'(flags), W'(4'b0110));

        // signed compare: 3 - 5 -> N=1 C=0; LT passes, GE fails
        op(CC_AL, OP_CMP, 1'b1, 32'd3, 32'd5);
        chk("cmp35_flags", W'(flags), W'(4'b1000));
        op(CC_LT, OP_MOV, 1'b0, 32'd0, 32'd77);
        chk("lt_exec", W'(execute), W'(1'b1));
        chk("lt_result", result, 32'd77);
        op(CC_GE, OP_MOV, 1'b0, 32'd0, 32'd88);
        chk("ge_ovalid", W'(out_valid), W'(1'b1));
        chk("ge_exec", W'(execute), W'(1'b0));
        chk("ge_wr", W'(wr_en), W'(1'b0));
        chk("ge_result", result, 32'd77);

        // carry chain: clear C, SBC, then ADC using the carry
        op(CC_AL, OP_ADD, 1'b1, 32'd1, 32'd1);
        chk("preC0_flags", W'(flags), W'(4'b0000));
        op(CC_AL, OP_SBC, 1'b1, 32'd10, 32'd3);
        chk("sbc_result", result, 32'd6);
        chk("sbc_flags", W'(flags), W'(4'b0010));
        op(CC_AL, OP_ADC, 1'b1, 32'hFFFF_FFFF, 32'd0);
        chk("adc_result", result, 32'd0);
        chk("adc_flags", W'(flags), W'(4'b0110));

        // MUL 7 x -3 with a held request during the busy period
        op(CC_AL, OP_MUL, 1'b1, 32'd7, 32'hFFFF_FFFD);
        cond = CC_AL; opcode = OP_ADD; set_flags = 1'b1;
        data1 = 32'd1; data2 = 32'd1; in_valid = 1'b1;
        chk("mul_busy_ready", W'(in_ready), W'(1'b0));
        chk("mul_busy_ovalid", W'(out_valid), W'(1'b0));
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mul_busy_cycles", W'(n), W'(W + 1));
        chk("mul_ovalid", W'(out_valid), W'(1'b1));
        chk("mul_result", result, 32'hFFFF_FFEB);
        chk("mul_exec", W'(execute), W'(1'b1));
        chk("mul_wr", W'(wr_en), W'(1'b1));
        chk("mul_flags", W'(flags), W'(4'b1010));
        @(posedge clk); #1;
        chk("mul_ignored_ovalid", W'(out_valid), W'(1'b0));
        chk("mul_ignored_flags", W'(flags), W'(4'b1010));

        // MUL with failing condition: no busy period
        op(CC_AL, OP_CMP, 1'b1, 32'd5, 32'd5);
        op(CC_AL, OP_ADD, 1'b0, 32'd2, 32'd3);
        chk("pre_mulne_result", result, 32'd5);
        op(CC_NE, OP_MUL, 1'b1, 32'd7, 32'd3);
        chk("mulne_ovalid", W'(out_valid), W'(1'b1));
        chk("mulne_exec", W'(execute), W'(1'b0));
        chk("mulne_wr", W'(wr_en), W'(1'b0));
        chk("mulne_ready", W'(in_ready), W'(1'b1));
        chk("mulne_result", result, 32'd5);
        chk("mulne_flags", W'(flags), W'(4'b0110));

        // undefined opcode
        op(CC_AL, 5'h1F, 1'b1, 32'd1, 32'd2);
        chk("undef_ovalid", W'(out_valid), W'(1'b1));
        chk("undef_exec", W'(execute), W'(1'b0));
        chk("undef_wr", W'(wr_en), W'(1'b0));
        chk("undef_result", result, 32'd0);
        chk("undef_flags", W'(flags), W'(4'b0110));

        // reset mid-MUL aborts without a result pulse
        op(CC_AL, OP_MUL, 1'b1, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midrst_flags", W'(flags), W'(4'b0000));
        chk("midrst_ready", W'(in_ready), W'(1'b0));
        chk("midrst_ovalid", W'(out_valid), W'(1'b0));
        chk("midrst_result", result, '0);
        @(negedge clk); reset = 1'b1; #1;
        chk("midrst_rel_ready", W'(in_ready), W'(1'b1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_pulse", W'(seen), W'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
